// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared types and default sizing for the parametrised
//                register file and its clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  // Clear sequencer states
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;

  // Default geometry: 8 registers of 8 bits
  localparam int c_DEF_DATA_WIDTH = 8;
  localparam int c_DEF_ADDR_WIDTH = 3;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_clear_seq
//  Description : Clear sequencer. On CLEAR it walks a pointer over every
//                register, issuing one clear-write per edge, holds BUSY while
//                doing so, and pulses DROP the cycle after any write request
//                that arrived while busy.
//  Ports       : CLK, RESET (async, active-low), CLEAR, WRITE1, WRITE2 (in)
//                BUSY, DROP, clr_we, clr_addr (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CLEAR,
  input  logic                  WRITE1,
  input  logic                  WRITE2,
  output logic                  BUSY,
  output logic                  DROP,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam int                   c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(c_DEPTH - 1);

  clr_state_t            r_state;
  clr_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic                  r_drop;
  logic                  w_busy;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      // Any write request seen while clearing is discarded; flag it next cycle
      r_drop  <= w_busy & (WRITE1 | WRITE2);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (CLEAR) begin
          w_state_next = CLEARING;
          w_ptr_next   = '0;
        end
      end
      CLEARING: begin
        // Pointer wraps to 0 naturally after the last register
        w_ptr_next = r_ptr + 1'b1;
        if (r_ptr == c_LAST) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  assign w_busy   = (r_state == CLEARING);
  assign BUSY     = w_busy;
  assign DROP     = r_drop;
  assign clr_we   = w_busy;
  assign clr_addr = r_ptr;

endmodule : reg_file_clear_seq
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : DEPTH x DATA_WIDTH register file, two write ports (port 2
//                wins on address collision), two combinational read ports,
//                optional same-cycle write bypass, optional hard-wired zero
//                register, and a sequenced hardware clear.
//  Ports       : CLK, RESET (async, active-low)
//                IN1/INADDRESS1/WRITE1, IN2/INADDRESS2/WRITE2 : write ports
//                OUT1ADDRESS/OUT1, OUT2ADDRESS/OUT2           : read ports
//                CLEAR (in), BUSY (out), DROP (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN1,
  input  logic [ADDR_WIDTH-1:0] INADDRESS1,
  input  logic                  WRITE1,
  input  logic [DATA_WIDTH-1:0] IN2,
  input  logic [ADDR_WIDTH-1:0] INADDRESS2,
  input  logic                  WRITE2,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  CLEAR,
  output logic                  BUSY,
  output logic                  DROP
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_we1;
  logic                  w_we2;

  reg_file_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .WRITE1   (WRITE1),
    .WRITE2   (WRITE2),
    .BUSY     (w_busy),
    .DROP     (DROP),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign BUSY = w_busy;

  // Port 1 yields to port 2 on a shared address; register 0 is read-only
  // when hard-wired to zero. Neither case is a DROP event.
  always_comb begin
    w_we1 = WRITE1 & ~w_busy;
    w_we2 = WRITE2 & ~w_busy;
    if (WRITE2 && (INADDRESS1 == INADDRESS2)) begin
      w_we1 = 1'b0;
    end
    if (ZERO_REG && (INADDRESS1 == '0)) begin
      w_we1 = 1'b0;
    end
    if (ZERO_REG && (INADDRESS2 == '0)) begin
      w_we2 = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else begin
      if (w_we1) begin
        r_regs[INADDRESS1] <= IN1;
      end
      if (w_we2) begin
        r_regs[INADDRESS2] <= IN2;
      end
    end
  end

  // Read muxes: array, then optional bypass (port 2 checked last so it wins),
  // then the zero-register override which also masks the bypass path.
  always_comb begin
    OUT1 = r_regs[OUT1ADDRESS];
    OUT2 = r_regs[OUT2ADDRESS];
    if (BYPASS && !w_busy) begin
      if (WRITE1 && (INADDRESS1 == OUT1ADDRESS)) OUT1 = IN1;
      if (WRITE2 && (INADDRESS2 == OUT1ADDRESS)) OUT1 = IN2;
      if (WRITE1 && (INADDRESS1 == OUT2ADDRESS)) OUT2 = IN1;
      if (WRITE2 && (INADDRESS2 == OUT2ADDRESS)) OUT2 = IN2;
    end
    if (ZERO_REG && (OUT1ADDRESS == '0)) OUT1 = '0;
    if (ZERO_REG && (OUT2ADDRESS == '0)) OUT2 = '0;
  end

endmodule : reg_file_param
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_param
//  Description : Directed self-checking bench. Three instances share the
//                stimulus: default (bypass on), bypass off, zero register on.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN1, IN2;
  logic [2:0] INADDRESS1, INADDRESS2, OUT1ADDRESS, OUT2ADDRESS;
  logic       WRITE1, WRITE2, CLEAR;

  logic [7:0] out1_b, out2_b, out1_n, out2_n, out1_z, out2_z;
  logic       busy_b, drop_b, busy_n, drop_n, busy_z, drop_z;

  int checks = 0;
  int errors = 0;

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN1(IN1), .INADDRESS1(INADDRESS1), .WRITE1(WRITE1),
    .IN2(IN2), .INADDRESS2(INADDRESS2), .WRITE2(WRITE2),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1_b), .OUT2(out2_b),
    .CLEAR(CLEAR), .BUSY(busy_b), .DROP(drop_b)
  );

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nb (
    .CLK(CLK), .RESET(RESET),
    .IN1(IN1), .INADDRESS1(INADDRESS1), .WRITE1(WRITE1),
    .IN2(IN2), .INADDRESS2(INADDRESS2), .WRITE2(WRITE2),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1_n), .OUT2(out2_n),
    .CLEAR(CLEAR), .BUSY(busy_n), .DROP(drop_n)
  );

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
    .CLK(CLK), .RESET(RESET),
    .IN1(IN1), .INADDRESS1(INADDRESS1), .WRITE1(WRITE1),
    .IN2(IN2), .INADDRESS2(INADDRESS2), .WRITE2(WRITE2),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1_z), .OUT2(out2_z),
    .CLEAR(CLEAR), .BUSY(busy_z), .DROP(drop_z)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WRITE1 = 1'b0; WRITE2 = 1'b0; CLEAR = 1'b0;
    IN1 = 8'h00; IN2 = 8'h00;
    INADDRESS1 = 3'd0; INADDRESS2 = 3'd0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    idle_inputs();
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7;
    #2;
    checks++;
    if (out1_b !== 8'h00 || out2_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: OUT1=%h OUT2=%h expected 00 00", out1_b, out2_b);
    end
    checks++;
    if (busy_b !== 1'b0 || drop_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: BUSY=%b DROP=%b expected 0 0", busy_b, drop_b);
    end
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_readback();
    WRITE1 = 1'b1; INADDRESS1 = 3'd3; IN1 = 8'h5A;
    WRITE2 = 1'b1; INADDRESS2 = 3'd5; IN2 = 8'hA5;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd1;
    tick();
    idle_inputs();
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
    #1;
    checks++;
    if (out1_b !== 8'h5A || out2_b !== 8'hA5) begin
      errors++;
      $display("FAIL readback: OUT1=%h OUT2=%h expected 5a a5", out1_b, out2_b);
    end
    checks++;
    if (out1_n !== 8'h5A || out2_n !== 8'hA5) begin
      errors++;
      $display("FAIL readback_nobypass: OUT1=%h OUT2=%h expected 5a a5", out1_n, out2_n);
    end
  endtask

  task automatic test_conflict();
    WRITE1 = 1'b1; INADDRESS1 = 3'd2; IN1 = 8'h11;
    WRITE2 = 1'b1; INADDRESS2 = 3'd2; IN2 = 8'h22;
    OUT1ADDRESS = 3'd2;
    #1;
    checks++;
    if (out1_b !== 8'h22) begin
      errors++;
      $display("FAIL conflict_bypass: OUT1=%h expected 22", out1_b);
    end
    tick();
    idle_inputs();
    OUT1ADDRESS = 3'd2;
    #1;
    checks++;
    if (out1_n !== 8'h22 || drop_n !== 1'b0) begin
      errors++;
      $display("FAIL conflict_write: r2=%h DROP=%b expected 22 0", out1_n, drop_n);
    end
  endtask

  task automatic test_bypass();
    WRITE1 = 1'b1; INADDRESS1 = 3'd4; IN1 = 8'h7E;
    OUT1ADDRESS = 3'd4;
    #1;
    checks++;
    if (out1_b !== 8'h7E) begin
      errors++;
      $display("FAIL bypass_on: OUT1=%h expected 7e", out1_b);
    end
    checks++;
    if (out1_n !== 8'h00) begin
      errors++;
      $display("FAIL bypass_off_before_edge: OUT1=%h expected 00", out1_n);
    end
    tick();
    idle_inputs();
    OUT1ADDRESS = 3'd4;
    #1;
    checks++;
    if (out1_n !== 8'h7E) begin
      errors++;
      $display("FAIL bypass_off_after_edge: OUT1=%h expected 7e", out1_n);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      WRITE1 = 1'b1; INADDRESS1 = 3'(2 * i);     IN1 = 8'hFF;
      WRITE2 = 1'b1; INADDRESS2 = 3'(2 * i + 1); IN2 = 8'hFF;
      tick();
    end
    idle_inputs();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    // Clear cycle k clears register k on its closing edge
    for (int k = 0; k < 8; k++) begin
      WRITE1 = 1'b0;
      OUT1ADDRESS = 3'(k);
      OUT2ADDRESS = (k == 3) ? 3'd6 : 3'(k - 1);
      #1;
      checks++;
      if (busy_b !== 1'b1 || out1_b !== 8'hFF) begin
        errors++;
        $display("FAIL clear_cycle%0d: BUSY=%b r%0d=%h expected 1 ff", k, busy_b, k, out1_b);
      end
      if (k == 3) begin
        WRITE1 = 1'b1; INADDRESS1 = 3'd6; IN1 = 8'h12;
        #1;
        checks++;
        if (out2_b !== 8'hFF) begin
          errors++;
          $display("FAIL clear_no_bypass: r6=%h expected ff", out2_b);
        end
      end else if (k > 0) begin
        checks++;
        if (out2_b !== 8'h00) begin
          errors++;
          $display("FAIL clear_prev%0d: r%0d=%h expected 00", k, k - 1, out2_b);
        end
      end
      if (k == 4 || k == 5) begin
        checks++;
        if (drop_b !== (k == 4)) begin
          errors++;
          $display("FAIL clear_drop%0d: DROP=%b expected %0d", k, drop_b, (k == 4));
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: BUSY=%b expected 0", busy_b);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a);
      #1;
      checks++;
      if (out1_b !== 8'h00) begin
        errors++;
        $display("FAIL clear_result: r%0d=%h expected 00", a, out1_b);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    idle_inputs();
    WRITE1 = 1'b1; INADDRESS1 = 3'd1; IN1 = 8'h44;
    WRITE2 = 1'b1; INADDRESS2 = 3'd7; IN2 = 8'h99;
    tick();
    idle_inputs();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL midclear_busy: BUSY=%b expected 0", busy_b);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a);
      #1;
      checks++;
      if (out1_b !== 8'h00) begin
        errors++;
        $display("FAIL midclear_regs: r%0d=%h expected 00", a, out1_b);
      end
    end
    tick();
    RESET = 1'b1;
    tick();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL midclear_rerun: busy cycles=%0d expected 8", n);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    WRITE1 = 1'b1; INADDRESS1 = 3'd0; IN1 = 8'h33;
    OUT1ADDRESS = 3'd0;
    #1;
    checks++;
    if (out1_z !== 8'h00 || out1_b !== 8'h33) begin
      errors++;
      $display("FAIL zero_bypass: zero OUT1=%h plain OUT1=%h expected 00 33", out1_z, out1_b);
    end
    tick();
    idle_inputs();
    OUT1ADDRESS = 3'd0;
    #1;
    checks++;
    if (out1_z !== 8'h00 || drop_z !== 1'b0) begin
      errors++;
      $display("FAIL zero_write: r0=%h DROP=%b expected 00 0", out1_z, drop_z);
    end
    checks++;
    if (out1_b !== 8'h33) begin
      errors++;
      $display("FAIL zero_plain: r0=%h expected 33", out1_b);
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_conflict();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_param
`default_nettype wire
